// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the memory stage and data memory.
interface mem_stage_if;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_req, mem_we, mem_wdata, mem_wmask,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_req, mem_we, mem_wdata, mem_wmask,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte/half/word loads and stores over a req/ready
// bus, ALU pass-through for non-memory ops, exception on bad access or timeout.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  fun3,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    mem_stage_if.master mem,
    output logic        stall_o,
    output logic        valid_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        exc_o
);

    typedef enum logic [0:0] {StIdle, StReq} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [2:0]  fun3_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic        store_q;
    logic [7:0]  wait_q;

    logic        mem_op;
    logic        is_store;
    logic        fun3_legal;
    logic        bad;
    logic        timeout;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    // A simultaneous load_en/store_en is treated as a store.
    assign is_store = store_en;
    assign mem_op   = valid_in & (load_en | store_en);
    assign timeout  = (state_q == StReq) & ~mem.mem_ready & (wait_q == 8'(MAX_WAIT - 1));

    // Legality and alignment check of the incoming access.
    always_comb begin
        fun3_legal = 1'b0;
        if (is_store) begin
            fun3_legal = (fun3 == 3'b000) | (fun3 == 3'b001) | (fun3 == 3'b010);
        end else begin
            fun3_legal = (fun3 == 3'b000) | (fun3 == 3'b001) | (fun3 == 3'b010) |
                         (fun3 == 3'b100) | (fun3 == 3'b101);
        end
        bad = ~fun3_legal |
              ((fun3[1:0] == 2'b01) & alu_res_in[0]) |
              ((fun3[1:0] == 2'b10) & (alu_res_in[1:0] != 2'b00));
    end

    // Store lane replication and byte-enable generation.
    always_comb begin
        lane_wdata = store_data_in;
        lane_wmask = 4'b1111;
        case (fun3[1:0])
            2'b00: begin
                lane_wdata = {4{store_data_in[7:0]}};
                lane_wmask = 4'b0001 << alu_res_in[1:0];
            end
            2'b01: begin
                lane_wdata = {2{store_data_in[15:0]}};
                lane_wmask = 4'b0011 << {alu_res_in[1], 1'b0};
            end
            default: begin
                lane_wdata = store_data_in;
                lane_wmask = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        // Halves are 2-aligned, so one shift serves both byte and half lanes.
        rdata_shift = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        case (fun3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'h0, rdata_shift[7:0]};
            3'b101:  load_data = {16'h0, rdata_shift[15:0]};
            default: load_data = mem.mem_rdata;
        endcase
    end

    assign mem.mem_req   = (state_q == StReq);
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_we    = (state_q == StReq) & store_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wmask = wmask_q;

    assign stall_o = ((state_q == StIdle) & mem_op & ~bad) |
                     ((state_q == StReq) & ~mem.mem_ready & ~timeout);

    // Access FSM with registered writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            wmask_q       <= 4'h0;
            fun3_q        <= 3'h0;
            rd_q          <= 5'h0;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            wait_q        <= 8'h0;
            valid_out     <= 1'b0;
            wb_data_out   <= 32'h0;
            rd_out        <= 5'h0;
            reg_write_out <= 1'b0;
            exc_o         <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            exc_o     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        rd_out <= rd_in;
                        if (mem_op && bad) begin
                            valid_out     <= 1'b1;
                            exc_o         <= 1'b1;
                            reg_write_out <= 1'b0;
                            wb_data_out   <= alu_res_in;
                        end else if (mem_op) begin
                            addr_q  <= alu_res_in;
                            wdata_q <= lane_wdata;
                            wmask_q <= lane_wmask;
                            fun3_q  <= fun3;
                            rd_q    <= rd_in;
                            load_q  <= ~is_store;
                            store_q <= is_store;
                            wait_q  <= 8'h0;
                            state_q <= StReq;
                        end else begin
                            valid_out     <= 1'b1;
                            wb_data_out   <= alu_res_in;
                            reg_write_out <= reg_write_in;
                        end
                    end
                end
                StReq: begin
                    if (mem.mem_ready) begin
                        valid_out     <= 1'b1;
                        wb_data_out   <= load_q ? load_data : addr_q;
                        rd_out        <= rd_q;
                        reg_write_out <= load_q;
                        state_q       <= StIdle;
                    end else if (timeout) begin
                        valid_out     <= 1'b1;
                        exc_o         <= 1'b1;
                        wb_data_out   <= addr_q;
                        rd_out        <= rd_q;
                        reg_write_out <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback results,
// a monitor pops and compares on every valid_out.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] alu_res_in;
    logic [31:0] store_data_in;
    logic [2:0]  fun3;
    logic        load_en;
    logic        store_en;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        stall_o;
    logic        valid_out;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        exc_o;

    mem_stage_if m();

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .alu_res_in    (alu_res_in),
        .store_data_in (store_data_in),
        .fun3          (fun3),
        .load_en       (load_en),
        .store_en      (store_en),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem           (m),
        .stall_o       (stall_o),
        .valid_out     (valid_out),
        .wb_data_out   (wb_data_out),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .exc_o         (exc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wb;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Memory model knobs: wait_cfg wait cycles before ready (255 = never).
    int          wait_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;
    int          wcnt = 0;

    // Bus snapshot taken during the last request of issue().
    logic [31:0] snap_addr;
    logic        snap_we;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_wmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic exc, input logic rw, input logic [4:0] rd,
                                input logic [31:0] wb);
        exp_t e;
        e.exc = exc;
        e.rw  = rw;
        e.rd  = rd;
        e.wb  = wb;
        return e;
    endfunction

    // Memory responder.
    initial begin
        m.mem_ready = 1'b0;
        m.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (m.mem_req) begin
                if (wcnt == wait_cfg) begin
                    m.mem_ready = 1'b1;
                    m.mem_rdata = rdata_cfg;
                    wcnt = 0;
                end else begin
                    m.mem_ready = 1'b0;
                    m.mem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                m.mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: compare every writeback against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got wb %h rd %0d, expected no output",
                             wb_data_out, rd_out);
                end else begin
                    e = sb.pop_front();
                    chk("wb_exc", {31'h0, exc_o}, {31'h0, e.exc});
                    chk("wb_reg_write", {31'h0, reg_write_out}, {31'h0, e.rw});
                    chk("wb_rd", {27'h0, rd_out}, {27'h0, e.rd});
                    if (!e.exc) chk("wb_data", wb_data_out, e.wb);
                end
            end
        end
    end

    // Present one instruction at posedge+1 and hold it until consumed.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic rw, output int stalls, output int reqs);
        valid_in      = 1'b1;
        load_en       = ld;
        store_en      = st;
        fun3          = f3;
        alu_res_in    = a;
        store_data_in = d;
        rd_in         = rd;
        reg_write_in  = rw;
        stalls = 0;
        reqs   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m.mem_req) begin
                reqs++;
                snap_addr  = m.mem_addr;
                snap_we    = m.mem_we;
                snap_wdata = m.mem_wdata;
                snap_wmask = m.mem_wmask;
            end
            if (!stall_o) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        if (stalls >= 40) begin
            tests++;
            fails++;
            $display("FAIL stall_bound: got %0d stall cycles, expected fewer than 40", stalls);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        load_en  = 1'b0;
        store_en = 1'b0;
    endtask

    initial begin
        int st;
        int rq;
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int rq;
        rst           = 1'b1;
        valid_in      = 1'b0;
        alu_res_in    = 32'h0;
        store_data_in = 32'h0;
        fun3          = 3'h0;
        load_en       = 1'b0;
        store_en      = 1'b0;
        rd_in         = 5'h0;
        reg_write_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_mem_req", {31'h0, m.mem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_exc", {31'h0, exc_o}, 32'h0);
        chk("rst_wb_data", wb_data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU pass-through.
        sb.push_back(mk(1'b0, 1'b1, 5'd5, 32'h0000_1234));
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, st, rq);
        chk("alu_stalls", st, 0);
        chk("alu_reqs", rq, 0);

        // LB / LBU at 0x103 with two wait cycles.
        wait_cfg  = 2;
        rdata_cfg = 32'h80FF_FF7F;
        sb.push_back(mk(1'b0, 1'b1, 5'd7, 32'hFFFF_FF80));
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, st, rq);
        chk("lb_stalls", st, 3);
        chk("lb_reqs", rq, 3);
        chk("lb_mem_addr", snap_addr, 32'h0000_0100);
        chk("lb_mem_we", {31'h0, snap_we}, 32'h0);
        sb.push_back(mk(1'b0, 1'b1, 5'd7, 32'h0000_0080));
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, st, rq);
        chk("lbu_stalls", st, 3);

        // Half and word loads, zero-wait.
        wait_cfg = 0;
        sb.push_back(mk(1'b0, 1'b1, 5'd11, 32'hFFFF_80FF));
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd11, 1'b1, st, rq);
        chk("lh_stalls", st, 1);
        sb.push_back(mk(1'b0, 1'b1, 5'd12, 32'h0000_80FF));
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd12, 1'b1, st, rq);
        sb.push_back(mk(1'b0, 1'b1, 5'd13, 32'h0000_FF7F));
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 5'd13, 1'b1, st, rq);
        sb.push_back(mk(1'b0, 1'b1, 5'd14, 32'h80FF_FF7F));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd14, 1'b1, st, rq);

        // SH at 0x202.
        sb.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0000_0202));
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd0, 1'b0, st, rq);
        chk("sh_stalls", st, 1);
        chk("sh_mem_we", {31'h0, snap_we}, 32'h1);
        chk("sh_wmask", {28'h0, snap_wmask}, 32'hC);
        chk("sh_wdata", snap_wdata, 32'h1234_1234);
        chk("sh_mem_addr", snap_addr, 32'h0000_0200);

        // SB at 0x101.
        sb.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0000_0101));
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 5'd0, 1'b0, st, rq);
        chk("sb_wmask", {28'h0, snap_wmask}, 32'h2);
        chk("sb_wdata", snap_wdata, 32'hABAB_ABAB);

        // Load and store both set: behaves as SW.
        sb.push_back(mk(1'b0, 1'b0, 5'd2, 32'h0000_0104));
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0104, 32'h0000_0055, 5'd2, 1'b1, st, rq);
        chk("ldst_mem_we", {31'h0, snap_we}, 32'h1);
        chk("ldst_wmask", {28'h0, snap_wmask}, 32'hF);
        chk("ldst_wdata", snap_wdata, 32'h0000_0055);

        // Misaligned LW and illegal fun3.
        sb.push_back(mk(1'b1, 1'b0, 5'd8, 32'h0));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 5'd8, 1'b1, st, rq);
        chk("lw_mis_stalls", st, 0);
        chk("lw_mis_reqs", rq, 0);
        sb.push_back(mk(1'b1, 1'b0, 5'd8, 32'h0));
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0, 5'd8, 1'b1, st, rq);
        chk("f3_011_reqs", rq, 0);
        sb.push_back(mk(1'b1, 1'b0, 5'd9, 32'h0));
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 5'd9, 1'b0, st, rq);
        chk("sh_mis_reqs", rq, 0);

        // Timeout with MAX_WAIT=4.
        wait_cfg = 255;
        sb.push_back(mk(1'b1, 1'b0, 5'd9, 32'h0));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9, 1'b1, st, rq);
        chk("to_reqs", rq, 4);
        chk("to_stalls", st, 4);
        @(negedge clk);
        chk("to_idle_req", {31'h0, m.mem_req}, 32'h0);
        @(posedge clk);
        #1;

        // Reset during the second REQ cycle.
        valid_in   = 1'b1;
        load_en    = 1'b1;
        fun3       = 3'b010;
        alu_res_in = 32'h0000_0500;
        rd_in      = 5'd10;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        load_en  = 1'b0;
        @(posedge clk);
        #1;
        chk("prerst_mem_req", {31'h0, m.mem_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'h0, m.mem_req}, 32'h0);
        chk("midrst_stall", {31'h0, stall_o}, 32'h0);
        chk("midrst_valid", {31'h0, valid_out}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b0, 1'b1, 5'd3, 32'h0000_CAFE));
        issue(1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 32'h0, 5'd3, 1'b1, st, rq);
        chk("post_rst_stalls", st, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline, sitting directly downstream of the execute stage and feeding writeback. It takes the ALU result as the effective address and performs byte/half/word loads and stores over a req/ready data-memory handshake. It stalls upstream while a transfer is outstanding, sign- or zero-extends load data, and passes non-memory results through with one cycle of latency. Misaligned or illegal accesses and memory timeouts raise an exception flag instead of issuing a transfer.

## Interface
- `MAX_WAIT`, default 16: maximum number of cycles in REQ without `mem_ready` before the access aborts (1..255).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: execute-stage result is valid this cycle.
- `alu_res_in` in 32: ALU result; the effective address for loads and stores.
- `store_data_in` in 32: rs2 value used by stores.
- `fun3` in 3: funct3 of the instruction (access size and signedness).
- `load_en` in 1: instruction is a load.
- `store_en` in 1: instruction is a store.
- `rd_in` in 5: destination register index.
- `reg_write_in` in 1: instruction writes rd.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `mem_wdata` out 32: write data, lane-replicated.
- `mem_wmask` out 4: byte-enable mask.
- `mem_rdata` in 32: read data; valid when `mem_req && mem_ready`.
- `mem_ready` in 1: memory completes the request this cycle.
- `stall_o` out 1: upstream must hold its outputs (combinational).
- `valid_out` out 1: writeback outputs are valid (one-cycle pulse per instruction).
- `wb_data_out` out 32: extended load data, or the ALU result for non-loads.
- `rd_out` out 5: registered copy of `rd_in`.
- `reg_write_out` out 1: registered write enable; forced to 0 on exception.
- `exc_o` out 1: exception pulse, aligned with `valid_out`.

## Operation
- State machine states: IDLE and REQ.
- Define `mem_op = valid_in & (load_en | store_en)`.
- Legal `fun3` for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal `fun3` for stores: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- An access is bad if any of these hold:
  - `fun3` is illegal;
  - the access is a halfword and `addr[0]` is 1;
  - the access is a word and `addr[1:0]` is not 0.
- IDLE transitions:
  - `mem_op` and not bad: capture address, data, mask, `fun3`, `rd` and the load/store flags, then go to REQ.
  - `mem_op` and bad: next cycle `valid_out`=1, `exc_o`=1, `reg_write_out`=0; no request is issued.
  - `valid_in` with no memory op: next cycle `valid_out`=1, `wb_data_out`=`alu_res_in`, `rd_out`/`reg_write_out` passed through.
  - `valid_in`=0: `valid_out`=0 next cycle.
- REQ behaviour:
  - `mem_req`=1. `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` come from registers and stay stable until completion.
  - All inputs except `mem_ready`/`mem_rdata` are ignored.
  - On `mem_ready`: next cycle `valid_out`=1. A load places extended data on `wb_data_out`; a store places the address. Return to IDLE.
  - Timeout: a wait counter counts REQ cycles with `mem_ready`=0. When it reaches `MAX_WAIT`, drop to IDLE; next cycle `valid_out`=1, `exc_o`=1, `reg_write_out`=0.
- Store lane formatting:
  - SB: `wdata` = `{4{b}}`, `mask` = `0001 << addr[1:0]`.
  - SH: `wdata` = `{2{h}}`, `mask` = `0011 << {addr[1],1'b0}`.
  - SW: `mask` = `1111`.
- Load extraction: select the byte lane `addr[1:0]` or the half lane `addr[1]` from `mem_rdata`. LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
- `stall_o = (IDLE & mem_op & !bad) | (REQ & !mem_ready & !timeout)`. A held instruction is therefore consumed exactly once.
- A simultaneous `load_en` and `store_en` is treated as a store.

## Timing
- Reset (asynchronous) values: state IDLE; all outputs 0; wait counter 0. Reset mid-REQ drops `mem_req` immediately, and no `valid_out` is produced for the aborted access.
- Non-memory instructions and bad accesses: latency 1 cycle, no stall.
- Memory access: accept cycle T (stall), REQ from T+1. With ready at T+1+k, `valid_out` is asserted at T+2+k. A zero-wait memory gives 2 cycles total and 1 stall cycle.
- `mem_req` never asserts in IDLE and never drops in REQ before ready or timeout.
- Back-to-back memory ops: the next op can be accepted in the cycle after completion.

## Test plan
- ALU pass-through: `alu_res_in`=0x1234, `rd_in`=5, `reg_write_in`=1 → next cycle `valid_out`=1, `wb_data_out`=0x1234, `rd_out`=5, `stall_o` never asserted.
- LB/LBU at address 0x103, memory returns 0x80FF_FF7F with 2 wait cycles → LB gives 0xFFFF_FF80 and LBU gives 0x0000_0080. `stall_o` is high for 3 cycles. `mem_addr`=0x100.
- SH at address 0x202, data 0xABCD_1234, zero-wait → `mem_we`=1, `mem_wmask`=1100, `mem_wdata`=0x1234_1234, `reg_write_out`=0.
- LW at address 0x301 → no `mem_req`; next cycle `exc_o`=1, `valid_out`=1, `reg_write_out`=0. Repeat with `fun3`=011 and get the same result.
- Timeout: `MAX_WAIT`=4, `mem_ready` held 0 → `mem_req` is high for exactly 4 cycles; then `exc_o`=1 and the stage is back in IDLE.
- Reset asserted during the second REQ cycle → `mem_req`, `stall_o` and `valid_out` go to 0 asynchronously. After release, the next ALU op is passed through normally.
